// File: rtl/deser8_collect.sv
// deser8_collect: collects eight serial bits into one byte.
// The byte is presented with a valid/ready handshake.
// A nonzero flag is registered alongside the byte.
module deser8_collect #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       sin,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] data_out,
   output logic       nonzero,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic       nz_q, nz_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic [2:0] wr_idx;

   // Map serial bit number k to its position in the assembled byte
   function automatic logic [2:0] bit_pos(input logic [2:0] k);
      return MSB_FIRST ? (3'd7 - k) : k;
   endfunction

   // Next-state logic: capture sin at the current bit slot, publish the byte after bit 7
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      nz_d    = nz_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      // In IDLE the incoming bit is always bit 0, whatever cnt holds
      wr_idx  = bit_pos((state_q == IDLE) ? 3'd0 : cnt_q);
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d         = 8'h00;
               sr_d[wr_idx] = sin;
               cnt_d        = 3'd1;
               state_d      = SHIFT;
               busy_d       = 1'b1;
            end
         end
         SHIFT: begin
            sr_d[wr_idx] = sin;
            cnt_d        = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               // The published byte includes the bit captured at this very edge
               data_d  = sr_d;
               nz_d    = |sr_d;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= 8'h00;
         cnt_q   <= 3'd0;
         data_q  <= 8'h00;
         nz_q    <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         nz_q    <= nz_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign out_valid = valid_q;
   assign data_out  = data_q;
   assign nonzero   = nz_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_deser8_collect.sv
// Directed testbench for deser8_collect.
// Two instances share all inputs: one LSB-first, one MSB-first.
module tb_deser8_collect;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sin;
   logic       out_ready;
   logic       vld_l, vld_m;
   logic [7:0] dat_l, dat_m;
   logic       nz_l, nz_m;
   logic       busy_l, busy_m;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   deser8_collect #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .out_ready(out_ready),
      .out_valid(vld_l), .data_out(dat_l), .nonzero(nz_l), .busy(busy_l)
   );

   deser8_collect #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .out_ready(out_ready),
      .out_valid(vld_m), .data_out(dat_m), .nonzero(nz_m), .busy(busy_m)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   // Advance one clock and settle just after the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outs(input string tag, input logic [7:0] d_l, input logic [7:0] d_m,
                                  input logic nzl, input logic nzm);
      check({tag, "_vld_l"}, {7'd0, vld_l}, 8'd0);
      check({tag, "_vld_m"}, {7'd0, vld_m}, 8'd0);
      check({tag, "_busy_l"}, {7'd0, busy_l}, 8'd0);
      check({tag, "_busy_m"}, {7'd0, busy_m}, 8'd0);
      check({tag, "_dat_l"}, dat_l, d_l);
      check({tag, "_dat_m"}, dat_m, d_m);
      check({tag, "_nz_l"}, {7'd0, nz_l}, {7'd0, nzl});
      check({tag, "_nz_m"}, {7'd0, nz_m}, {7'd0, nzm});
   endtask

   // Send bits b[0]..b[7] starting with start at E0; optional stray start at bit glitch_k.
   // Returns just after E7 with the byte checked on both instances.
   task automatic send_frame(input string tag, input logic [7:0] b, input int glitch_k);
      start = 1'b1;
      sin   = b[0];
      step();
      check({tag, "_busy_e0"}, {6'd0, busy_m, busy_l}, 8'h03);
      start = 1'b0;
      for (int k = 1; k < 8; k++) begin
         sin   = b[k];
         start = (k == glitch_k);
         step();
         if (k < 7) check({tag, "_early_vld"}, {6'd0, vld_m, vld_l}, 8'h00);
      end
      start = 1'b0;
      sin   = 1'b0;
      check({tag, "_vld"}, {6'd0, vld_m, vld_l}, 8'h03);
      check({tag, "_dat_l"}, dat_l, b);
      check({tag, "_dat_m"}, dat_m, rev8(b));
      check({tag, "_nz"}, {6'd0, nz_m, nz_l}, (b != 8'h00) ? 8'h03 : 8'h00);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      sin       = 1'b0;
      out_ready = 1'b1;

      // Reset for two cycles
      step();
      step();
      rst_n = 1'b1;
      check_idle_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0);

      // Toggling sin without start never produces a byte
      for (int i = 0; i < 10; i++) begin
         sin = i[0];
         step();
         check("idle_toggle_vld", {6'd0, vld_m, vld_l}, 8'h00);
      end

      // LSB-first frame 1,0,1,1,0,0,1,0 -> 4D (B2 on the MSB-first instance)
      out_ready = 1'b1;
      send_frame("f4d", 8'h4D, -1);
      step();
      check_idle_outs("f4d_post", 8'h4D, 8'hB2, 1'b1, 1'b1);

      // Back-to-back frame: start sampled at E9
      send_frame("b2b", 8'h96, -1);
      step();
      check_idle_outs("b2b_post", 8'h96, 8'h69, 1'b1, 1'b1);

      // Zero frame with ready low for 5 cycles
      out_ready = 1'b0;
      send_frame("zero", 8'h00, -1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("zero_hold_vld", {6'd0, vld_m, vld_l}, 8'h03);
         check("zero_hold_dat", dat_l | dat_m, 8'h00);
      end
      out_ready = 1'b1;
      step();
      check_idle_outs("zero_post", 8'h00, 8'h00, 1'b0, 1'b0);

      // Placement: 1,0,0,0,0,0,0,1 -> 81 on both; 1,1,0,... -> 03 / C0
      send_frame("p81", 8'h81, -1);
      step();
      send_frame("p03", 8'h03, -1);
      step();
      check_idle_outs("p03_post", 8'h03, 8'hC0, 1'b1, 1'b1);

      // Stray start during SHIFT bit 3 and during HOLD (incl. handshake cycle)
      out_ready = 1'b0;
      send_frame("ign", 8'h1D, 3);
      start = 1'b1;
      step();
      step();
      check("ign_hold_vld", {6'd0, vld_m, vld_l}, 8'h03);
      check("ign_hold_dat_l", dat_l, 8'h1D);
      out_ready = 1'b1;
      step();
      start = 1'b0;
      check_idle_outs("ign_hs", 8'h1D, 8'hB8, 1'b1, 1'b1);
      step();
      check_idle_outs("ign_noframe", 8'h1D, 8'hB8, 1'b1, 1'b1);

      // Reset mid-frame after bit 4 of FF
      start = 1'b1;
      sin   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_idle_outs("midrst", 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("midrst_novld", {6'd0, vld_m, vld_l}, 8'h00);
      end
      sin = 1'b0;
      send_frame("a5", 8'hA5, -1);
      step();
      check_idle_outs("a5_post", 8'hA5, 8'hA5, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
